// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/freeze handling and a write-back-to-decode operand bypass.
module idex_hazard_reg #(
  parameter int Depth    = 32,
  parameter int RegAddrW = 5,
  parameter int CntW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [Depth-1:0]    id_rs1_data,
  input  logic [Depth-1:0]    id_rs2_data,
  input  logic [Depth-1:0]    id_imm,
  input  logic [RegAddrW-1:0] id_rs1,
  input  logic [RegAddrW-1:0] id_rs2,
  input  logic [RegAddrW-1:0] id_rd,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [7:0]          id_ctrl,
  input  logic                wb_reg_write,
  input  logic [RegAddrW-1:0] wb_rd,
  input  logic [Depth-1:0]    wb_data,
  input  logic                flush,
  input  logic                mem_stall,
  output logic                ex_valid,
  output logic [Depth-1:0]    ex_rs1_data,
  output logic [Depth-1:0]    ex_rs2_data,
  output logic [Depth-1:0]    ex_imm,
  output logic [RegAddrW-1:0] ex_rs1,
  output logic [RegAddrW-1:0] ex_rs2,
  output logic [RegAddrW-1:0] ex_rd,
  output logic [7:0]          ex_ctrl,
  output logic                hazard_stall,
  output logic [CntW-1:0]     bubble_count
);

  // id_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0]}
  localparam int CtrlMemRead = 6;

  logic                flush_pending;
  logic                load_use;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                byp_rs1;
  logic                byp_rs2;
  logic                bubble;
  logic [Depth-1:0]    rs1_data_sel;
  logic [Depth-1:0]    rs2_data_sel;
  logic [CntW-1:0]     bubble_count_inc;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_ctrl[CtrlMemRead] && (ex_rd != '0) && id_valid
                    && (rs1_hit || rs2_hit);

  assign hazard_stall = load_use && !mem_stall && !flush && !flush_pending;

  // x0 is hardwired to zero, so a write-back to it must never be forwarded.
  assign byp_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign byp_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

  assign rs1_data_sel = byp_rs1 ? wb_data : id_rs1_data;
  assign rs2_data_sel = byp_rs2 ? wb_data : id_rs2_data;

  assign bubble           = flush || flush_pending || load_use;
  assign bubble_count_inc = (&bubble_count) ? bubble_count : bubble_count + CntW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
      ex_valid      <= 1'b0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_ctrl       <= '0;
      bubble_count  <= '0;
    end else if (mem_stall) begin
      // Frozen pipe: remember a flush so it is applied once the stall lifts.
      if (flush) begin
        flush_pending <= 1'b1;
      end
    end else if (bubble) begin
      flush_pending <= 1'b0;
      ex_valid      <= 1'b0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_ctrl       <= '0;
      bubble_count  <= bubble_count_inc;
    end else begin
      ex_valid      <= id_valid;
      ex_rs1_data   <= rs1_data_sel;
      ex_rs2_data   <= rs2_data_sel;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_ctrl       <= id_valid ? id_ctrl : 8'h00;
    end
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Self-checking bench for idex_hazard_reg: directed scenarios plus randomized
// traffic against a transaction-level reference model of the ID/EX slot.
module tb_idex_hazard_reg;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [W-1:0]  id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic [7:0]    id_ctrl;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic          flush, mem_stall;
  logic          ex_valid;
  logic [W-1:0]  ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [7:0]    ex_ctrl;
  logic          hazard_stall;
  logic [CW-1:0] bubble_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the instruction currently sitting in EX, plus counters.
  typedef struct {
    bit          valid;
    bit [W-1:0]  rs1_data, rs2_data, imm;
    bit [AW-1:0] rs1, rs2, rd;
    bit [7:0]    ctrl;
  } slot_t;

  slot_t       m_ex;
  bit          m_pend;
  int unsigned m_cnt;

  idex_hazard_reg #(.Depth(W), .RegAddrW(AW), .CntW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_ex   = '{default: '0};
    m_pend = 1'b0;
    m_cnt  = 0;
  endfunction

  // An instruction in ID needs a value that the load in EX has not fetched yet.
  function automatic bit model_load_use();
    bit reads_it;
    reads_it = (id_uses_rs1 && id_rs1 == m_ex.rd) || (id_uses_rs2 && id_rs2 == m_ex.rd);
    return m_ex.valid && m_ex.ctrl[6] && m_ex.rd != 0 && id_valid && reads_it;
  endfunction

  function automatic bit model_stall();
    return model_load_use() && !mem_stall && !flush && !m_pend;
  endfunction

  function automatic bit [W-1:0] rf_read(bit [AW-1:0] idx, bit [W-1:0] rf_data);
    if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
    return rf_data;
  endfunction

  function automatic void model_edge();
    if (mem_stall) begin
      if (flush) m_pend = 1'b1;
    end else if (flush || m_pend || model_load_use()) begin
      m_ex   = '{default: '0};
      m_pend = 1'b0;
      m_cnt  = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m_ex.valid    = id_valid;
      m_ex.rs1_data = rf_read(id_rs1, id_rs1_data);
      m_ex.rs2_data = rf_read(id_rs2, id_rs2_data);
      m_ex.imm      = id_imm;
      m_ex.rs1      = id_rs1;
      m_ex.rs2      = id_rs2;
      m_ex.rd       = id_rd;
      m_ex.ctrl     = id_valid ? id_ctrl : 8'h00;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_ctrl = '0; wb_reg_write = 0; wb_rd = '0; wb_data = '0;
    flush = 0; mem_stall = 0;
  endtask

  // Present "lw rd, 0(x1)" in ID so the next edge puts it in EX.
  task automatic present_load(input bit [AW-1:0] rd);
    id_valid = 1; id_rs1 = 1; id_rs2 = 0; id_rd = rd;
    id_uses_rs1 = 1; id_uses_rs2 = 0; id_ctrl = 8'b1101_1000;
    id_rs1_data = 32'h0000_1000; id_imm = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    #12;
    n_chk++;
    if ({ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
         hazard_stall, bubble_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ex_valid=%0b ex_ctrl=%h ex_rd=%0d bubble_count=%0d expected all zero",
               ex_valid, ex_ctrl, ex_rd, bubble_count);
    end
    rst_n = 1;
    #3;
  endtask

  task automatic test_load_use();
    int unsigned c0;
    present_load(5);
    tick();
    id_valid = 1; id_rs1 = 5; id_rs2 = 7; id_rd = 6; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_ctrl = 8'h82; id_rs1_data = 32'h0; id_rs2_data = 32'h7;
    c0 = m_cnt;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall: got %0b want 1", hazard_stall);
    end
    tick();
    n_chk++;
    if (ex_valid !== 1'b0 || bubble_count !== CW'(c0 + 1) || hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_bubble: ex_valid=%0b cnt=%0d stall=%0b want 0/%0d/0",
               ex_valid, bubble_count, hazard_stall, c0 + 1);
    end
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || bubble_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL load_use_reissue: ex_valid=%0b ex_rs1=%0d ex_rd=%0d cnt=%0d want 1/5/6/%0d",
               ex_valid, ex_rs1, ex_rd, bubble_count, c0 + 1);
    end
  endtask

  task automatic test_no_use();
    int unsigned c0;
    present_load(5);
    tick();
    id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_rd = 5; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_ctrl = 8'h88; id_imm = 32'h0001_2000;
    c0 = m_cnt;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL no_use_stall: got %0b want 0", hazard_stall);
    end
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || bubble_count !== CW'(c0) || ex_imm !== 32'h0001_2000) begin
      n_fail++;
      $display("FAIL no_use_load: ex_valid=%0b cnt=%0d imm=%h want 1/%0d/00012000",
               ex_valid, bubble_count, ex_imm, c0);
    end
  endtask

  task automatic test_bypass();
    id_valid = 1; id_rs1 = 3; id_rs2 = 4; id_rd = 8; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_ctrl = 8'h80; id_rs1_data = 32'h1111_1111; id_rs2_data = 32'h2222_2222;
    wb_reg_write = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
    tick();
    n_chk++;
    if (ex_rs1_data !== 32'hDEAD_BEEF || ex_rs2_data !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL bypass_rs1: rs1_data=%h rs2_data=%h want deadbeef/22222222",
               ex_rs1_data, ex_rs2_data);
    end
    id_rs1 = 0; wb_rd = 0;
    tick();
    n_chk++;
    if (ex_rs1_data !== 32'h1111_1111) begin
      n_fail++; $display("FAIL bypass_x0: rs1_data=%h want 11111111", ex_rs1_data);
    end
    id_rs1 = 2; id_rs2 = 9; wb_rd = 9; wb_data = 32'hCAFE_0009;
    tick();
    n_chk++;
    if (ex_rs2_data !== 32'hCAFE_0009 || ex_rs1_data !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL bypass_rs2: rs1_data=%h rs2_data=%h want 11111111/cafe0009",
               ex_rs1_data, ex_rs2_data);
    end
    wb_reg_write = 0;
  endtask

  task automatic test_stall_flush();
    slot_t       snap;
    int unsigned c0;
    id_valid = 1; id_rs1 = 10; id_rs2 = 11; id_rd = 12; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_ctrl = 8'h83; id_rs1_data = 32'hA5A5_0001; id_rs2_data = 32'h5A5A_0002; id_imm = 32'h44;
    tick();
    snap = '{1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 32'h44, 5'd10, 5'd11, 5'd12, 8'h83};
    c0 = m_cnt;
    id_rs1 = 20; id_rs2 = 21; id_rd = 22; id_ctrl = 8'h81; id_rs1_data = 32'h0BAD_0BAD;
    mem_stall = 1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      flush = (cyc == 2);
      tick();
      n_chk++;
      if (ex_valid !== snap.valid || ex_rs1_data !== snap.rs1_data || ex_rd !== snap.rd ||
          ex_ctrl !== snap.ctrl || bubble_count !== CW'(c0)) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: valid=%0b rs1_data=%h rd=%0d ctrl=%h cnt=%0d want 1/a5a50001/12/83/%0d",
                 cyc, ex_valid, ex_rs1_data, ex_rd, ex_ctrl, bubble_count, c0);
      end
    end
    flush = 0; mem_stall = 0;
    tick();
    n_chk++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || bubble_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL stall_pending_flush: valid=%0b ctrl=%h cnt=%0d want 0/00/%0d",
               ex_valid, ex_ctrl, bubble_count, c0 + 1);
    end
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd22 || bubble_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL stall_pending_cleared: valid=%0b rd=%0d cnt=%0d want 1/22/%0d",
               ex_valid, ex_rd, bubble_count, c0 + 1);
    end
  endtask

  task automatic test_flush_load_use();
    int unsigned c0;
    present_load(7);
    tick();
    id_valid = 1; id_rs1 = 0; id_rs2 = 7; id_rd = 9; id_uses_rs1 = 1; id_uses_rs2 = 1; id_ctrl = 8'h80;
    flush = 1;
    c0 = m_cnt;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_lu_stall: got %0b want 0", hazard_stall);
    end
    tick();
    flush = 0;
    n_chk++;
    if (ex_valid !== 1'b0 || bubble_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL flush_lu_bubble: valid=%0b cnt=%0d want 0/%0d", ex_valid, bubble_count, c0 + 1);
    end
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || bubble_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL flush_lu_single: valid=%0b rd=%0d cnt=%0d want 1/9/%0d",
               ex_valid, ex_rd, bubble_count, c0 + 1);
    end
  endtask

  task automatic test_stall_load_use();
    int unsigned c0;
    present_load(4);
    tick();
    id_valid = 1; id_rs1 = 4; id_rs2 = 0; id_rd = 13; id_uses_rs1 = 1; id_uses_rs2 = 0; id_ctrl = 8'h80;
    mem_stall = 1;
    c0 = m_cnt;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_lu_stall: got %0b want 0", hazard_stall);
    end
    tick();
    mem_stall = 0;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b1 || ex_rd !== 5'd4 || bubble_count !== CW'(c0)) begin
      n_fail++;
      $display("FAIL stall_lu_reeval: stall=%0b rd=%0d cnt=%0d want 1/4/%0d",
               hazard_stall, ex_rd, bubble_count, c0);
    end
    tick();
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd13 || bubble_count !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL stall_lu_after: valid=%0b rd=%0d cnt=%0d want 1/13/%0d",
               ex_valid, ex_rd, bubble_count, c0 + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs1       = AW'($urandom_range(0, 3));
      id_rs2       = AW'($urandom_range(0, 3));
      id_rd        = AW'($urandom_range(0, 3));
      id_uses_rs1  = $urandom_range(0, 1);
      id_uses_rs2  = $urandom_range(0, 1);
      id_ctrl      = 8'($urandom);
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      wb_reg_write = $urandom_range(0, 1);
      wb_rd        = AW'($urandom_range(0, 3));
      wb_data      = $urandom;
      flush        = ($urandom_range(0, 9) == 0);
      mem_stall    = ($urandom_range(0, 6) == 0);
      #1;
      n_chk++;
      if (hazard_stall !== model_stall()) begin
        n_fail++;
        $display("FAIL rand_stall[%0d]: got %0b want %0b", i, hazard_stall, model_stall());
      end
      tick();
      n_chk++;
      if (ex_valid !== m_ex.valid || ex_ctrl !== m_ex.ctrl || ex_rd !== m_ex.rd ||
          ex_rs1 !== m_ex.rs1 || ex_rs2 !== m_ex.rs2 || ex_imm !== m_ex.imm ||
          ex_rs1_data !== m_ex.rs1_data || ex_rs2_data !== m_ex.rs2_data ||
          bubble_count !== m_cnt[CW-1:0]) begin
        n_fail++;
        $display("FAIL rand_ex[%0d]: valid=%0b ctrl=%h rd=%0d d1=%h d2=%h cnt=%0d want %0b/%h/%0d/%h/%h/%0d",
                 i, ex_valid, ex_ctrl, ex_rd, ex_rs1_data, ex_rs2_data, bubble_count,
                 m_ex.valid, m_ex.ctrl, m_ex.rd, m_ex.rs1_data, m_ex.rs2_data, m_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    flush = 1;
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      tick();
      if (m_cnt == CNT_MAX - 1) begin
        n_chk++;
        if (bubble_count !== CW'(CNT_MAX - 1)) begin
          n_fail++; $display("FAIL sat_approach: cnt=%0d want %0d", bubble_count, CNT_MAX - 1);
        end
      end
    end
    n_chk++;
    if (bubble_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: cnt=%h want ffff", bubble_count);
    end
    tick();
    n_chk++;
    if (bubble_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_no_wrap: cnt=%h want ffff", bubble_count);
    end
    flush = 0;
  endtask

  task automatic test_async_reset();
    id_valid = 1; id_rs1 = 2; id_rs2 = 3; id_rd = 4; id_ctrl = 8'h80; id_rs1_data = 32'h77;
    tick();
    mem_stall = 1; flush = 1;
    tick();
    #2;
    rst_n = 0;
    model_clear();
    #1;
    n_chk++;
    if ({ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
         hazard_stall, bubble_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b rd=%0d ctrl=%h cnt=%0d want all zero",
               ex_valid, ex_rd, ex_ctrl, bubble_count);
    end
    #8;
    mem_stall = 0; flush = 0;
    rst_n = 1;
    tick();
    n_chk++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || bubble_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_clears_pending: valid=%0b rd=%0d cnt=%0d want 1/4/0",
               ex_valid, ex_rd, bubble_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_use();
    test_bypass();
    test_stall_flush();
    test_flush_load_use();
    test_stall_load_use();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
